water_led_seq: RTL and testbench

- Sequencer that drives the 4-bit position code consumed by the running-light LED decoder. The decoder lights one of 8 LEDs for codes 0..7, and all LEDs are off for any other code.
- Produces a timed position sequence on a 12 MHz board clock.
- Supports forward, reverse and ping-pong patterns, four speeds, pause with single-step, and blanking.
- Sits between the board-level key/switch logic and the LED decoder.

---
 rtl/water_led_pkg.sv | 23 ++
 rtl/water_led_tick.sv | 48 ++++
 rtl/water_led_seq.sv | 141 ++++++++++++++
 tb/tb_water_led_seq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/water_led_pkg.sv
// Shared encodings for the running-light sequencer: states, pattern modes,
// travel direction and the blank position code.
package water_led_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam logic [1:0] MODE_FWD  = 2'b00;
    localparam logic [1:0] MODE_REV  = 2'b01;
    localparam logic [1:0] MODE_PING = 2'b10;

    // Any code outside 0..7 turns every LED off at the decoder.
    localparam logic [3:0] POS_BLANK = 4'd15;

endpackage

// File: rtl/water_led_tick.sv
// Step prescaler: fires once every DIV_BASE << speed_sel enabled cycles and
// holds its count while disabled, so a pause resumes mid-period.
module water_led_tick #(
    parameter int DIV_BASE = 1200000,
    parameter int CNT_W    = 24
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       en,
    input  logic       clr,
    input  logic [1:0] speed_sel,
    output logic       tick
);

    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] BASE = CNT_W'(DIV_BASE);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_m1;

    assign period_m1 = (BASE << speed_sel) - ONE;

    // Compare with >= so that lowering speed_sel mid-count fires at once
    // instead of running the counter up to its wrap.
    assign tick = en && !clr && (cnt_q >= period_m1);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        cnt_d = cnt_q;
        if (clr || tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + ONE;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/water_led_seq.sv
// Running-light sequencer: IDLE/RUN/PAUSE control plus forward, reverse and
// ping-pong position stepping, feeding a 4-bit code to the LED decoder.
module water_led_seq
    import water_led_pkg::*;
#(
    parameter int DIV_BASE = 1200000,
    parameter int NUM_POS  = 8,
    parameter int CNT_W    = 24
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       enable,
    input  logic       hold,
    input  logic       step_pulse,
    input  logic [1:0] mode_sel,
    input  logic [1:0] speed_sel,
    output logic [3:0] heart_cnt,
    output logic       cycle_done
);

    localparam logic [3:0] POS_LAST = 4'(NUM_POS - 1);

    state_e     state_q, state_d;
    dir_e       dir_q, dir_d;
    logic [3:0] pos_q, pos_d;
    logic       done_q, done_d;

    logic       presc_en, presc_clr, tick;
    logic       adv;
    logic [3:0] adv_pos;
    dir_e       adv_dir;
    logic       adv_wrap;

    assign presc_en  = (state_q == ST_RUN);
    assign presc_clr = !enable || (state_q == ST_IDLE);

    water_led_tick #(
        .DIV_BASE (DIV_BASE),
        .CNT_W    (CNT_W)
    ) u_tick (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .en        (presc_en),
        .clr       (presc_clr),
        .speed_sel (speed_sel),
        .tick      (tick)
    );

    // Candidate next position under the current mode; used by both tick and step.
    always_comb begin
        adv_pos  = pos_q;
        adv_dir  = dir_q;
        adv_wrap = 1'b0;
        case (mode_sel)
            MODE_REV: begin
                if (pos_q == 4'd0) begin
                    adv_pos  = POS_LAST;
                    adv_wrap = 1'b1;
                end else begin
                    adv_pos = pos_q - 4'd1;
                end
            end
            MODE_PING: begin
                if (pos_q == POS_LAST) begin
                    adv_dir = DIR_DOWN;
                end else if (pos_q == 4'd0) begin
                    adv_dir = DIR_UP;
                end
                if (adv_dir == DIR_DOWN) begin
                    adv_pos  = pos_q - 4'd1;
                    adv_wrap = (pos_q == 4'd1);
                end else begin
                    adv_pos = pos_q + 4'd1;
                end
            end
            default: begin
                if (pos_q == POS_LAST) begin
                    adv_pos  = 4'd0;
                    adv_wrap = 1'b1;
                end else begin
                    adv_pos = pos_q + 4'd1;
                end
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        adv     = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
            pos_d   = POS_BLANK;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = hold ? ST_PAUSE : ST_RUN;
                    pos_d   = (mode_sel == MODE_REV) ? POS_LAST : 4'd0;
                    dir_d   = DIR_UP;
                end
                ST_RUN: begin
                    adv     = tick;
                    state_d = hold ? ST_PAUSE : ST_RUN;
                end
                ST_PAUSE: begin
                    adv     = step_pulse;
                    state_d = hold ? ST_PAUSE : ST_RUN;
                end
                default: begin
                    state_d = ST_IDLE;
                    pos_d   = POS_BLANK;
                end
            endcase
        end
        if (adv) begin
            pos_d  = adv_pos;
            dir_d  = adv_dir;
            done_d = adv_wrap;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_UP;
            pos_q   <= POS_BLANK;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            pos_q   <= pos_d;
            done_q  <= done_d;
        end
    end

    assign heart_cnt  = pos_q;
    assign cycle_done = done_q;

endmodule

// File: tb/tb_water_led_seq.sv
// Self-checking bench for water_led_seq: directed scenarios followed by
// randomized stimulus, all compared against a behavioural position model.
module tb_water_led_seq;

    localparam int DIV = 4;
    localparam int N   = 8;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       hold = 1'b0;
    logic       step_pulse = 1'b0;
    logic [1:0] mode_sel = 2'd0;
    logic [1:0] speed_sel = 2'd0;
    logic [3:0] heart_cnt;
    logic       cycle_done;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;

    // Behavioural model: position, run/pause/idle, cycles since last advance.
    int m_state;
    int m_pos;
    int m_elapsed;
    bit m_up;
    bit m_done;

    water_led_seq #(
        .DIV_BASE (DIV),
        .NUM_POS  (N),
        .CNT_W    (24)
    ) dut (
        .clk_in     (clk),
        .rst_n_in   (rst_n),
        .enable     (enable),
        .hold       (hold),
        .step_pulse (step_pulse),
        .mode_sel   (mode_sel),
        .speed_sel  (speed_sel),
        .heart_cnt  (heart_cnt),
        .cycle_done (cycle_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_state   = M_IDLE;
        m_pos     = 15;
        m_elapsed = 0;
        m_up      = 1'b1;
        m_done    = 1'b0;
    endfunction

    // Ping-pong is treated as a walk around a ring of 2*(N-1) slots:
    // slot k shows position k on the way up and 2*(N-1)-k on the way down.
    function automatic void model_advance(input int mode);
        int len;
        int k;
        len = 2 * (N - 1);
        case (mode)
            1: begin
                m_done = (m_pos == 0);
                m_pos  = (m_pos + N - 1) % N;
            end
            2: begin
                k      = (m_pos == 0 || m_pos == N - 1 || m_up) ? m_pos : len - m_pos;
                k      = (k + 1) % len;
                m_pos  = (k < N) ? k : len - k;
                m_up   = (k >= 1 && k <= N - 1);
                m_done = (k == 0);
            end
            default: begin
                m_done = (m_pos == N - 1);
                m_pos  = (m_pos + 1) % N;
            end
        endcase
    endfunction

    function automatic void model_edge(input bit e, input bit h, input bit s,
                                       input int mode, input int sp);
        int per;
        bit adv;
        per    = DIV << sp;
        adv    = 1'b0;
        m_done = 1'b0;
        if (!e) begin
            m_state   = M_IDLE;
            m_pos     = 15;
            m_elapsed = 0;
        end else if (m_state == M_IDLE) begin
            m_pos     = (mode == 1) ? N - 1 : 0;
            m_up      = 1'b1;
            m_elapsed = 0;
            m_state   = h ? M_PAUSE : M_RUN;
        end else begin
            if (m_state == M_RUN) begin
                if (m_elapsed >= per - 1) begin
                    adv       = 1'b1;
                    m_elapsed = 0;
                end else begin
                    m_elapsed++;
                end
            end else begin
                adv = s;
            end
            if (adv) model_advance(mode);
            m_state = h ? M_PAUSE : M_RUN;
        end
    endfunction

    // Called at a falling edge: drive inputs, predict the next edge, then
    // compare after it at the following falling edge.
    task automatic cyc(input bit e, input bit h, input bit s,
                       input logic [1:0] mode, input logic [1:0] sp);
        enable     = e;
        hold       = h;
        step_pulse = s;
        mode_sel   = mode;
        speed_sel  = sp;
        model_edge(e, h, s, int'(mode), int'(sp));
        @(negedge clk);
        check("heart_cnt", heart_cnt, m_pos);
        check("cycle_done", cycle_done, m_done);
        if (cycle_done) done_cnt++;
    endtask

    initial begin
        bit e, h, s;
        logic [1:0] md, sp;

        model_reset();
        repeat (2) @(negedge clk);
        check("reset_heart", heart_cnt, 15);
        check("reset_done", cycle_done, 0);
        rst_n = 1'b1;

        // Forward, speed 0: one full lap with a single wrap pulse.
        cyc(1, 0, 0, 2'd0, 2'd0);
        check("fwd_start", heart_cnt, 0);
        done_cnt = 0;
        repeat (33) cyc(1, 0, 0, 2'd0, 2'd0);
        check("fwd_wraps", done_cnt, 1);
        repeat (2) cyc(0, 0, 0, 2'd0, 2'd0);

        // Reverse, speed 1: starts at the top, one lap.
        cyc(1, 0, 0, 2'd1, 2'd1);
        check("rev_start", heart_cnt, 7);
        done_cnt = 0;
        repeat (64) cyc(1, 0, 0, 2'd1, 2'd1);
        check("rev_wraps", done_cnt, 1);
        check("rev_end", heart_cnt, 7);
        repeat (2) cyc(0, 0, 0, 2'd1, 2'd1);

        // Ping-pong: 15 advances land on position 1 with one 1->0 pulse.
        cyc(1, 0, 0, 2'd2, 2'd0);
        done_cnt = 0;
        repeat (60) cyc(1, 0, 0, 2'd2, 2'd0);
        check("ping_wraps", done_cnt, 1);
        check("ping_end", heart_cnt, 1);

        // Pause mid-count, three single steps, then resume the partial period.
        repeat (2) cyc(1, 0, 0, 2'd2, 2'd0);
        repeat (20) cyc(1, 1, 0, 2'd2, 2'd0);
        check("pause_frozen", heart_cnt, 1);
        repeat (3) begin
            cyc(1, 1, 1, 2'd2, 2'd0);
            cyc(1, 1, 0, 2'd2, 2'd0);
        end
        check("pause_steps", heart_cnt, 4);
        cyc(1, 0, 0, 2'd2, 2'd0);
        check("resume_wait", heart_cnt, 4);
        cyc(1, 0, 0, 2'd2, 2'd0);
        check("resume_tick", heart_cnt, 5);

        // Disable on the tick cycle, then restart with a full period.
        repeat (3) cyc(1, 0, 0, 2'd2, 2'd0);
        cyc(0, 0, 0, 2'd2, 2'd0);
        check("disable_blank", heart_cnt, 15);
        check("disable_done", cycle_done, 0);
        cyc(1, 0, 0, 2'd0, 2'd0);
        check("reenable_start", heart_cnt, 0);
        repeat (3) cyc(1, 0, 0, 2'd0, 2'd0);
        check("reenable_hold", heart_cnt, 0);
        cyc(1, 0, 0, 2'd0, 2'd0);
        check("reenable_tick", heart_cnt, 1);

        // Speed 3 -> 0 with the count at 20: immediate advance, then spacing 4.
        cyc(0, 0, 0, 2'd0, 2'd3);
        cyc(1, 0, 0, 2'd0, 2'd3);
        repeat (20) cyc(1, 0, 0, 2'd0, 2'd3);
        check("speed_before", heart_cnt, 0);
        cyc(1, 0, 0, 2'd0, 2'd0);
        check("speed_drop", heart_cnt, 1);
        repeat (4) cyc(1, 0, 0, 2'd0, 2'd0);
        check("speed_spacing", heart_cnt, 2);

        // Asynchronous reset between clock edges.
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_heart", heart_cnt, 15);
        check("async_rst_done", cycle_done, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 0, 0, 2'd1, 2'd0);
        check("post_rst_start", heart_cnt, 7);

        // Randomized traffic against the model.
        e  = 1'b1;
        h  = 1'b0;
        md = 2'd2;
        sp = 2'd0;
        for (int i = 0; i < 4000; i++) begin
            e = ($urandom_range(0, 149) != 0);
            if ($urandom_range(0, 19) == 0) h = ~h;
            s = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 49) == 0) md = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) sp = 2'($urandom_range(0, 3));
            cyc(e, h, s, md, sp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
